// File: rtl/multicycle_ripple_adder.sv
// Multi-cycle add/subtract: one SLICE-bit ripple stage reused NSLICE times with a registered carry.
// Optional signed-overflow output `ovf` enabled by defining ADDER_OVF_EN.
module mra_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);
  logic [SLICE:0] t;
  assign t  = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};
  assign s  = t[SLICE-1:0];
  assign co = t[SLICE];
endmodule

module multicycle_ripple_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NSLICE = (SLICE > 0) ? WIDTH / SLICE : 1;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

  if (SLICE < 1 || (WIDTH % ((SLICE < 1) ? 1 : SLICE)) != 0) begin : g_bad_cfg
    $error("multicycle_ripple_adder: WIDTH must be a positive multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] op_a, op_b, work, work_nxt;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [SLICE-1:0] sl_a, sl_b, sl_sum;
  logic             sl_co;

  assign sl_a = op_a[idx*SLICE +: SLICE];
  assign sl_b = op_b[idx*SLICE +: SLICE];

  mra_slice #(.SLICE(SLICE)) u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry),
    .s  (sl_sum),
    .co (sl_co)
  );

  // Merge the slice being finished so the last slice lands in s on the same edge.
  always_comb begin
    work_nxt = work;
    work_nxt[idx*SLICE +: SLICE] = sl_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

`ifdef ADDER_OVF_EN
  logic c_msb;
  // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
  assign c_msb = sl_a[SLICE-1] ^ sl_b[SLICE-1] ^ sl_sum[SLICE-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      work  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      s     <= '0;
      co    <= 1'b0;
`ifdef ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          op_a  <= a;
          op_b  <= sub ? ~b : b;
          carry <= sub ? 1'b1 : cin;
          idx   <= '0;
        end
        BUSY: begin
          work  <= work_nxt;
          carry <= sl_co;
          idx   <= idx + IDXW'(1);
          if (idx == LAST) begin
            s  <= work_nxt;
            co <= sl_co;
`ifdef ADDER_OVF_EN
            ovf <= c_msb ^ sl_co;
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_ripple_adder.sv
// Scoreboard bench for multicycle_ripple_adder (WIDTH=16, SLICE=4); honours ADDER_OVF_EN.
module tb_multicycle_ripple_adder;
  localparam int W  = 16;
  localparam int NS = 4;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         start = 0, sub = 0, cin = 0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, co;
  logic [W-1:0] s;
`ifdef ADDER_OVF_EN
  logic         ovf;
`endif

  multicycle_ripple_adder #(.WIDTH(W), .SLICE(NS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
    .a(a), .b(b), .busy(busy), .done(done), .s(s), .co(co)
`ifdef ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(bit sb, bit ci, logic [W-1:0] aa, logic [W-1:0] bb);
    exp_t   e;
    longint ua, ub, sa, sbv, r, sr;
    ua = aa; ub = bb;
    sa = $signed(aa); sbv = $signed(bb);
    if (sb) begin
      r = ua - ub; sr = sa - sbv; e.co = (ua >= ub);
    end else begin
      r = ua + ub + ci; sr = sa + sbv + ci; e.co = (r >= (64'd1 << W));
    end
    e.s   = W'(r & ((64'd1 << W) - 1));
    e.ovf = (sr > (64'sd1 << (W-1)) - 1) || (sr < -(64'sd1 << (W-1)));
    e.due = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      bit exp_busy, exp_done;
      exp_busy = (q.size() > 0) && (cyc < q[0].due);
      exp_done = (q.size() > 0) && (cyc == q[0].due);
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      if ((done || exp_done) && q.size() > 0) begin
        if (done) begin
          chk("s", s, q[0].s);
          chk("co", co, q[0].co);
`ifdef ADDER_OVF_EN
          chk("ovf", ovf, q[0].ovf);
`endif
        end
        void'(q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("idle_timeout", 1, 0);
  endtask

  task automatic issue(bit sb, bit ci, logic [W-1:0] aa, logic [W-1:0] bb);
    exp_t e;
    wait_idle();
    a = aa; b = bb; sub = sb; cin = ci; start = 1;
    @(posedge clk); #1;
    start = 0;
    e = model(sb, ci, aa, bb);
    e.due = cyc + NS;
    q.push_back(e);
    last = e;
    // Operand changes after the start edge must not affect this operation.
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s", s, 0);
    chk("rst_co", co, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    issue(0, 0, 16'h0001, 16'h0001);
    issue(0, 0, 16'hFFFF, 16'h0001);
    issue(0, 1, 16'h000E, 16'h000E);
    issue(1, 0, 16'h0005, 16'h0007);
    issue(1, 1, 16'h0007, 16'h0005);
    issue(1, 0, 16'h8000, 16'h8000);
    issue(0, 1, 16'hFFFF, 16'hFFFF);
    issue(0, 0, 16'h7FFF, 16'h0001);
    issue(1, 0, 16'h8000, 16'h0001);
    issue(0, 0, 16'h0003, 16'h0004);

    // Requests during BUSY and the DONE cycle are dropped.
    issue(0, 0, 16'h0010, 16'h0020);
    begin
      int n = 0;
      a = 16'h1111; b = 16'h1111; sub = 0; start = 1;
      while (!done && n < 20) begin @(posedge clk); #1; n++; end
      if (n >= 20) chk("done_timeout", 1, 0);
      @(posedge clk); #1;
      start = 0;
      repeat (4) @(posedge clk);
      #1;
      chk("hold_s", s, 16'h0030);
      chk("hold_co", co, 0);
    end

    // Reset in the second BUSY cycle aborts the operation.
    issue(0, 0, 16'h1111, 16'h2222);
    @(posedge clk); #1;
    rst_n = 0;
    q.delete();
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_s", s, 0);
    chk("abort_co", co, 0);
`ifdef ADDER_OVF_EN
    chk("abort_ovf", ovf, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1;
    issue(0, 0, 16'h1234, 16'h4321);
    chk("model_5555", last.s, 16'h5555);

    for (int i = 0; i < 40; i++)
      issue(1'($urandom), 1'($urandom), pick(), pick());

    begin
      int n = 0;
      while (q.size() > 0 && n < 100) begin @(posedge clk); n++; end
      chk("drain", q.size(), 0);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("final_hold_s", s, last.s);
    chk("final_hold_co", co, last.co);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
